// File: rtl/mul_pkg.sv
// Shared types and constants for the round-robin multiplier scheduler.
package mul_pkg;

  localparam int MUL_SIZE_DEF = 80;
  // Multiplier result latency in cycles from the en edge to a valid res.
  localparam int MUL_LAT      = 2;
  // Cycles spent in WAIT between ISSUE and CAPT.
  localparam int WAIT_CYC     = MUL_LAT - 1;
  // Operands are split into this many chunks per side (4x4 = 16 partial products).
  localparam int PP_SPLIT     = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPT,
    RESP
  } state_t;

endpackage

// File: rtl/mul_rr_sched_rr_arbiter.sv
// Round-robin arbiter: first set request at or above ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  // Rotating priority search; only the first hit is granted.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (en && !any && req[(int'(ptr) + k) % NREQ]) begin
        any                           = 1'b1;
        gnt[(int'(ptr) + k) % NREQ]   = 1'b1;
        idx                           = ID_W'((int'(ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/multiplier.sv
// Two-stage multiplier: en latches 16 partial products, and the following
// cycle with en low sums them into res.
module multiplier
  import mul_pkg::*;
#(
  parameter int MUL_SIZE = MUL_SIZE_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [MUL_SIZE-1:0]   a,
  input  logic [MUL_SIZE-1:0]   b,
  output logic [2*MUL_SIZE-1:0] res
);

  localparam int CW = MUL_SIZE / PP_SPLIT;

  logic [PP_SPLIT-1:0][PP_SPLIT-1:0][2*CW-1:0] pp;
  logic                                        pend;
  logic [2*MUL_SIZE-1:0]                       sum;

  // Stage 1: chunk-by-chunk partial products captured on the en pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pp   <= '0;
      pend <= 1'b0;
    end else begin
      pend <= en;
      if (en) begin
        for (int i = 0; i < PP_SPLIT; i++)
          for (int j = 0; j < PP_SPLIT; j++)
            pp[i][j] <= (2*CW)'(a[i*CW +: CW]) * (2*CW)'(b[j*CW +: CW]);
      end
    end
  end

  // Weighted sum of the partial products.
  always_comb begin
    sum = '0;
    for (int i = 0; i < PP_SPLIT; i++)
      for (int j = 0; j < PP_SPLIT; j++)
        sum = sum + ((2*MUL_SIZE)'(pp[i][j]) << ((i + j) * CW));
  end

  // Stage 2: sum only once en has dropped after a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           res <= '0;
    else if (pend && !en) res <= sum;
  end

endmodule

// File: rtl/mul_rr_sched.sv
// Shares one two-stage multiplier between NREQ requesters in round-robin order
// and returns tagged products on a single response channel.
module mul_rr_sched
  import mul_pkg::*;
#(
  parameter  int MUL_SIZE = MUL_SIZE_DEF,
  parameter  int NREQ     = 4,
  localparam int ID_W     = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*MUL_SIZE-1:0] req_a,
  input  logic [NREQ*MUL_SIZE-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [2*MUL_SIZE-1:0]    rsp_data,
  output logic                     busy,
  output logic [15:0]              done_cnt
);

  state_t                state;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       id_q;
  logic [MUL_SIZE-1:0]   op_a;
  logic [MUL_SIZE-1:0]   op_b;
  logic                  mul_en;
  logic [1:0]            wait_cnt;
  logic [2*MUL_SIZE-1:0] res;
  logic [NREQ-1:0]       gnt;
  logic [ID_W-1:0]       gnt_idx;
  logic                  gnt_any;

  // Grants are only offered while idle, so req_ready is silent otherwise.
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .en  (state == IDLE),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  multiplier #(.MUL_SIZE(MUL_SIZE)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mul_en),
    .a     (op_a),
    .b     (op_b),
    .res   (res)
  );

  assign req_ready = gnt;
  assign busy      = (state != IDLE);

  // Scheduler FSM: grant, pulse en once, wait out the multiplier, hold the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id_q      <= '0;
      op_a      <= '0;
      op_b      <= '0;
      mul_en    <= 1'b0;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      done_cnt  <= '0;
    end else begin
      mul_en <= 1'b0;
      unique case (state)
        IDLE: if (gnt_any) begin
          op_a   <= req_a[int'(gnt_idx)*MUL_SIZE +: MUL_SIZE];
          op_b   <= req_b[int'(gnt_idx)*MUL_SIZE +: MUL_SIZE];
          id_q   <= gnt_idx;
          rr_ptr <= ID_W'((int'(gnt_idx) + 1) % NREQ);
          mul_en <= 1'b1;
          state  <= ISSUE;
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 2'(WAIT_CYC - 1)) state <= CAPT;
          else                              wait_cnt <= wait_cnt + 2'd1;
        end
        CAPT: begin
          rsp_data  <= res;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          done_cnt  <= done_cnt + 16'd1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The multiplier needs en low for a cycle between pulses.
  a_no_b2b_en: assert property (@(posedge clk) disable iff (!rst_n) mul_en |=> !mul_en);

endmodule

// File: tb/tb_mul_rr_sched.sv
// Bench for mul_rr_sched: vector table plus directed corner sequences,
// responses checked against a scoreboard queue.
module tb_mul_rr_sched;

  localparam int MS = 80;
  localparam int NR = 4;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*MS-1:0] req_a;
  logic [NR*MS-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IW-1:0]    rsp_id;
  logic [2*MS-1:0]  rsp_data;
  logic             busy;
  logic [15:0]      done_cnt;

  mul_rr_sched #(.MUL_SIZE(MS), .NREQ(NR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [IW-1:0]   id;
    logic [2*MS-1:0] data;
  } exp_t;

  typedef struct {
    int              id;
    logic [MS-1:0]   a;
    logic [MS-1:0]   b;
    logic [2*MS-1:0] exp;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[6];

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string name, input logic [2*MS-1:0] act, input logic [2*MS-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Response monitor: every accepted product must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) check("rsp_unexpected", 1, 0);
      else begin
        mon_e = sb.pop_front();
        check("rsp_id", rsp_id, mon_e.id);
        check("rsp_data", rsp_data, mon_e.data);
      end
    end
  end

  // Track en pulses and any back-to-back occurrence.
  int   en_cnt  = 0;
  int   en_b2b  = 0;
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (dut.mul_en === 1'b1) begin
      en_cnt++;
      if (prev_en) en_b2b++;
    end
    prev_en = dut.mul_en;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout expected completion");
    $fatal(1);
  end

  // Call at a negedge; waits for a one-hot grant to id.
  task automatic wait_grant(input int id, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (req_ready == NR'(1 << id)) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_any(output int gi, output bit ok);
    ok = 1'b0;
    gi = -1;
    for (int k = 0; k < 64; k++) begin
      if (req_ready != '0) begin
        for (int i = 0; i < NR; i++) if (req_ready[i]) gi = i;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic issue(input int id, input logic [MS-1:0] a, input logic [MS-1:0] b,
                       input logic [2*MS-1:0] exp);
    bit ok;
    @(posedge clk); #1;
    req_valid[id]        = 1'b1;
    req_a[id*MS +: MS]   = a;
    req_b[id*MS +: MS]   = b;
    @(negedge clk);
    wait_grant(id, ok);
    check("grant_seen", ok, 1);
    if (ok) sb.push_back('{IW'(id), exp});
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy && !rsp_valid) begin ok = 1'b1; break; end
    end
    check("drain", ok, 1);
  endtask

  logic [2*MS-1:0] allsq;
  logic [MS-1:0]   ones;
  logic [MS-1:0]   ra, rb;
  int              g, lat, gi, last, rv, ec;
  bit              ok;
  logic [15:0]     dc;

  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    ones  = '1;
    allsq = ~(2*MS)'(0) - ((2*MS)'(1) << (MS + 1)) + (2*MS)'(2);
    ra    = {$urandom, $urandom, $urandom};
    rb    = {$urandom, $urandom, $urandom};

    vecs[0] = '{2, ones, ones, allsq};
    vecs[1] = '{1, '0, rb, '0};
    vecs[2] = '{0, 80'd123456789, 80'd987654321, 160'd121932631112635269};
    vecs[3] = '{2, 80'd1 << 79, 80'd2, 160'd1 << 80};
    vecs[4] = '{1, ra, rb, (2*MS)'(ra) * (2*MS)'(rb)};
    vecs[5] = '{3, 80'd1, ones, (2*MS)'(ones)};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_done_cnt", done_cnt, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single op: 3*5 on requester 0, response 4 cycles after grant
    @(posedge clk); #1;
    req_valid[0]   = 1'b1;
    req_a[0 +: MS] = 80'd3;
    req_b[0 +: MS] = 80'd5;
    @(negedge clk);
    wait_grant(0, ok);
    check("single_grant", ok, 1);
    g = cyc;
    sb.push_back('{IW'(0), (2*MS)'(15)});
    @(posedge clk); #1 req_valid[0] = 1'b0;
    @(negedge clk);
    check("single_ready_pulse", req_ready, 0);
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      if (rsp_valid) begin lat = cyc - g; break; end
      check("single_busy", busy, 1);
      @(negedge clk);
    end
    check("single_latency", lat, 4);
    drain();
    check("single_done_cnt", done_cnt, 1);

    // Vector table
    for (int i = 0; i < 6; i++) issue(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp);
    drain();
    check("table_done_cnt", done_cnt, 7);

    // Fairness: all requesters held, grants 0,1,2,3,0 five cycles apart
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) begin
      req_valid[i]       = 1'b1;
      req_a[i*MS +: MS]  = MS'(i + 1);
      req_b[i*MS +: MS]  = MS'(1000 + i);
    end
    @(negedge clk);
    last = 0;
    for (int n = 0; n < 5; n++) begin
      wait_any(gi, ok);
      check("rr_grant_seen", ok, 1);
      check("rr_grant_order", gi, n % NR);
      if (n > 0) check("rr_grant_gap", cyc - last, 5);
      last = cyc;
      if (ok) sb.push_back('{IW'(gi), (2*MS)'((gi + 1) * (1000 + gi))});
      @(negedge clk);
    end
    @(posedge clk); #1 req_valid = '0;
    drain();

    // Pointer wrap: grant to 3, then 0 and 3 together -> 0
    issue(3, 80'd2, 80'd3, 160'd6);
    drain();
    @(posedge clk); #1;
    req_valid[0]     = 1'b1;
    req_valid[3]     = 1'b1;
    req_a[0 +: MS]   = 80'd5;
    req_b[0 +: MS]   = 80'd5;
    @(negedge clk);
    wait_any(gi, ok);
    check("wrap_grant", req_ready, 4'b0001);
    if (ok) sb.push_back('{IW'(gi), (2*MS)'(25)});
    @(posedge clk); #1 req_valid = '0;
    drain();

    // Backpressure: response held 10 cycles, no grant, no en
    rsp_ready = 1'b0;
    issue(1, 80'd11, 80'd13, 160'd143);
    @(posedge clk); #1;
    req_valid[2]     = 1'b1;
    req_a[2*MS +: MS] = 80'd4;
    req_b[2*MS +: MS] = 80'd5;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    check("bp_rsp_seen", ok, 1);
    ec = en_cnt;
    for (int k = 0; k < 10; k++) begin
      check("bp_rsp_data", rsp_data, 143);
      check("bp_rsp_id", rsp_id, 1);
      check("bp_req_ready", req_ready, 0);
      @(negedge clk);
    end
    check("bp_no_en", en_cnt, ec);
    dc = done_cnt;
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_done_inc", done_cnt, dc + 16'd1);
    wait_grant(2, ok);
    check("bp_next_grant", ok, 1);
    if (ok) sb.push_back('{IW'(2), (2*MS)'(20)});
    @(posedge clk); #1 req_valid = '0;
    drain();

    // Reset during WAIT: outputs clear, product discarded
    @(posedge clk); #1;
    req_valid[0]   = 1'b1;
    req_a[0 +: MS] = 80'd6;
    req_b[0 +: MS] = 80'd7;
    @(negedge clk);
    wait_grant(0, ok);
    check("rstmid_grant", ok, 1);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_rsp_valid", rsp_valid, 0);
    check("rstmid_req_ready", req_ready, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_rsp_data", rsp_data, 0);
    check("rstmid_rsp_id", rsp_id, 0);
    check("rstmid_done_cnt", done_cnt, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    rv = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) rv++;
    end
    check("rstmid_no_rsp", rv, 0);
    issue(2, 80'd100, 80'd200, 160'd20000);
    drain();
    check("rstmid_done_cnt_after", done_cnt, 1);

    check("en_never_b2b", en_b2b, 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
